lsu_dcache: RTL and testbench

Direct-mapped, write-through, no-write-allocate data cache directly downstream of the LSU. It services the LSU memory request (address, read enable, write enable, write data). It returns the read data and a completion strobe, which the LSU consumes as its dcache_valid input. Misses and all stores go to a single-port backing memory over a req/ack handshake. One 16-bit word per line; word addressing.

---
 rtl/lsu_dcache_pkg.sv | 12 +
 rtl/lsu_dcache_array.sv | 37 +++
 rtl/lsu_dcache.sv | 90 +++++++++
 tb/tb_lsu_dcache.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_dcache_pkg.sv
// lsu_dcache_pkg: shared types, default widths, LSU opcodes and saturating increment for the data cache
package lsu_dcache_pkg;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_INDEX_W = 4;
    localparam logic [3:0] LW = 4'b0100;
    localparam logic [3:0] SW = 4'b0101;
    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return v + {15'd0, v != 16'hFFFF};
    endfunction
endpackage

// File: rtl/lsu_dcache_array.sv
// lsu_dcache_array: direct-mapped valid/tag/data storage, combinational read, one synchronous write port
//   clk_i, rst_i            : clock, sync active-high reset (clears valid bits only)
//   rd_index -> rd_valid/rd_tag/rd_data : combinational lookup
//   wr_en, wr_index, wr_tag, wr_data    : line write, sets valid
module lsu_dcache_array import lsu_dcache_pkg::*; #(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int TAG_W   = DEF_ADDR_W - DEF_INDEX_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data
);
    logic [2**INDEX_W-1:0] valid;
    logic [TAG_W-1:0]      tags [2**INDEX_W];
    logic [DATA_W-1:0]     data [2**INDEX_W];
    always_ff @(posedge clk_i) begin
        if (rst_i) valid <= '0;
        else if (wr_en) valid[wr_index] <= 1'b1;
    end
    always_ff @(posedge clk_i) begin
        if (wr_en && !rst_i) begin
            tags[wr_index] <= wr_tag;
            data[wr_index] <= wr_data;
        end
    end
    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[rd_index];
endmodule

// File: rtl/lsu_dcache.sv
// lsu_dcache: direct-mapped write-through no-write-allocate data cache between the LSU and backing memory
//   LSU side    : mem_addr_i, mem_read_en_i, mem_write_en_i, mem_write_data_i -> mem_read_data_o, dcache_valid_o
//   memory side : bmem_req_o, bmem_we_o, bmem_addr_o, bmem_wdata_o <- bmem_rdata_i, bmem_ack_i
//   stats       : hit_cnt_o, miss_cnt_o (saturating load hit/miss counts)
module lsu_dcache import lsu_dcache_pkg::*; #(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int INDEX_W = DEF_INDEX_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic              mem_read_en_i,
    input  logic              mem_write_en_i,
    input  logic [DATA_W-1:0] mem_write_data_i,
    output logic [DATA_W-1:0] mem_read_data_o,
    output logic              dcache_valid_o,
    output logic              bmem_req_o,
    output logic              bmem_we_o,
    output logic [ADDR_W-1:0] bmem_addr_o,
    output logic [DATA_W-1:0] bmem_wdata_o,
    input  logic [DATA_W-1:0] bmem_rdata_i,
    input  logic              bmem_ack_i,
    output logic [15:0]       hit_cnt_o,
    output logic [15:0]       miss_cnt_o
);
    localparam int TAG_W = ADDR_W - INDEX_W;
    state_t state_q, state_d;
    logic [ADDR_W-1:0] look_addr;
    logic [TAG_W-1:0]  arr_tag;
    logic [DATA_W-1:0] arr_data, rd_q;
    logic arr_valid, idle, rd_req, hit, idle_hit, fill_ack, write_ack;
    // in WRITE the hit is re-evaluated against the latched store address
    always_comb begin
        idle            = state_q == IDLE;
        rd_req          = mem_read_en_i && !mem_write_en_i;
        look_addr       = idle ? mem_addr_i : bmem_addr_o;
        hit             = arr_valid && arr_tag == look_addr[ADDR_W-1:INDEX_W];
        idle_hit        = !rst_i && idle && rd_req && hit;
        fill_ack        = !rst_i && state_q == FILL && bmem_ack_i;
        write_ack       = !rst_i && state_q == WRITE && bmem_ack_i;
        state_d         = idle ? (mem_write_en_i ? WRITE : (rd_req && !hit) ? FILL : IDLE)
                               : (bmem_ack_i ? IDLE : state_q);
        dcache_valid_o  = idle_hit || fill_ack || write_ack;
        mem_read_data_o = idle_hit ? arr_data : fill_ack ? bmem_rdata_i : rd_q;
    end
    lsu_dcache_array #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_array (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .rd_index (look_addr[INDEX_W-1:0]),
        .rd_valid (arr_valid),
        .rd_tag   (arr_tag),
        .rd_data  (arr_data),
        .wr_en    (fill_ack || (write_ack && hit)),
        .wr_index (bmem_addr_o[INDEX_W-1:0]),
        .wr_tag   (bmem_addr_o[ADDR_W-1:INDEX_W]),
        .wr_data  (fill_ack ? bmem_rdata_i : bmem_wdata_o)
    );
    always_ff @(posedge clk_i) state_q <= rst_i ? IDLE : state_d;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bmem_req_o   <= 1'b0;
            bmem_we_o    <= 1'b0;
            bmem_addr_o  <= '0;
            bmem_wdata_o <= '0;
            hit_cnt_o    <= '0;
            miss_cnt_o   <= '0;
            rd_q         <= '0;
        end else begin
            if (idle && mem_write_en_i) begin
                bmem_req_o   <= 1'b1;
                bmem_we_o    <= 1'b1;
                bmem_addr_o  <= mem_addr_i;
                bmem_wdata_o <= mem_write_data_i;
            end else if (idle && rd_req && !hit) begin
                bmem_req_o  <= 1'b1;
                bmem_we_o   <= 1'b0;
                bmem_addr_o <= mem_addr_i;
                miss_cnt_o  <= sat_inc(miss_cnt_o);
            end else if (fill_ack || write_ack) begin
                bmem_req_o <= 1'b0;
            end
            if (idle_hit) begin
                hit_cnt_o <= sat_inc(hit_cnt_o);
                rd_q      <= arr_data;
            end
            if (fill_ack) rd_q <= bmem_rdata_i;
        end
    end
endmodule

// File: tb/tb_lsu_dcache.sv
// tb_lsu_dcache: randomized self-checking bench with a backing-memory responder and an address-level cache model
module tb_lsu_dcache;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] mem_addr_i, mem_write_data_i, mem_read_data_o;
    logic        mem_read_en_i, mem_write_en_i, dcache_valid_o;
    logic        bmem_req_o, bmem_we_o, bmem_ack_i;
    logic [15:0] bmem_addr_o, bmem_wdata_o, bmem_rdata_i;
    logic [15:0] hit_cnt_o, miss_cnt_o;

    logic [15:0] bm [65536];
    logic [15:0] line_addr [16];
    logic        line_v [16];
    int          n_checks = 0, n_fail = 0, exp_hits = 0, exp_misses = 0;
    logic [15:0] last_rd;

    always #5 clk_i = ~clk_i;

    lsu_dcache dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_addr_i(mem_addr_i), .mem_read_en_i(mem_read_en_i), .mem_write_en_i(mem_write_en_i),
        .mem_write_data_i(mem_write_data_i), .mem_read_data_o(mem_read_data_o), .dcache_valid_o(dcache_valid_o),
        .bmem_req_o(bmem_req_o), .bmem_we_o(bmem_we_o), .bmem_addr_o(bmem_addr_o), .bmem_wdata_o(bmem_wdata_o),
        .bmem_rdata_i(bmem_rdata_i), .bmem_ack_i(bmem_ack_i), .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    task automatic model_reset();
        for (int i = 0; i < 16; i++) line_v[i] = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        last_rd = 16'h0;
    endtask

    // One LSU request; the bench plays backing memory (ack after lat request cycles, stray acks while idle)
    task automatic access(input logic wr, input logic both, input logic [15:0] addr, input logic [15:0] wd, input int lat);
        bit exp_hit, done;
        int cyc, reqc;
        logic [15:0] exp_data;
        exp_hit = !wr && line_v[addr[3:0]] && line_addr[addr[3:0]] == addr;
        exp_data = bm[addr];
        mem_addr_i = addr;
        mem_write_data_i = wd;
        mem_write_en_i = wr;
        mem_read_en_i = !wr || both;
        done = 0;
        cyc = 0;
        reqc = 0;
        while (!done && cyc < 64) begin
            bmem_ack_i = 1'b0;
            bmem_rdata_i = 16'($urandom);
            if (bmem_req_o) begin
                reqc++;
                if (reqc == lat) begin
                    bmem_ack_i = 1'b1;
                    if (!bmem_we_o) bmem_rdata_i = bm[bmem_addr_o];
                end
            end else begin
                bmem_ack_i = ($urandom_range(0, 3) == 0);
            end
            @(negedge clk_i);
            if (bmem_req_o) begin
                n_checks++;
                if (bmem_addr_o !== addr || bmem_we_o !== wr || (wr && bmem_wdata_o !== wd)) begin
                    n_fail++;
                    $display("FAIL bmem_request addr=%h we=%b wdata=%h, expected addr=%h we=%b wdata=%h",
                             bmem_addr_o, bmem_we_o, bmem_wdata_o, addr, wr, wd);
                end
            end
            if (dcache_valid_o) begin
                done = 1;
                n_checks++;
                if ((reqc == 0) !== exp_hit || (!exp_hit && reqc != lat)) begin
                    n_fail++;
                    $display("FAIL completion addr=%h got hit=%0d req_cycles=%0d, expected hit=%0d req_cycles=%0d",
                             addr, reqc == 0, reqc, exp_hit, exp_hit ? 0 : lat);
                end
                if (!wr) begin
                    n_checks++;
                    if (mem_read_data_o !== exp_data) begin
                        n_fail++;
                        $display("FAIL load_data addr=%h got %h expected %h", addr, mem_read_data_o, exp_data);
                    end
                end
            end
            if (bmem_ack_i && bmem_req_o && bmem_we_o) bm[bmem_addr_o] = bmem_wdata_o;
            @(posedge clk_i);
            #1;
            cyc++;
        end
        mem_read_en_i = 1'b0;
        mem_write_en_i = 1'b0;
        bmem_ack_i = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout addr=%h no dcache_valid_o within 64 cycles", addr);
        end
        if (!wr) begin
            if (exp_hit) exp_hits++;
            else begin
                exp_misses++;
                line_v[addr[3:0]] = 1'b1;
                line_addr[addr[3:0]] = addr;
            end
            last_rd = exp_data;
        end
        @(negedge clk_i);
        n_checks++;
        if (hit_cnt_o !== 16'(exp_hits) || miss_cnt_o !== 16'(exp_misses)) begin
            n_fail++;
            $display("FAIL counters got hit=%0d miss=%0d expected hit=%0d miss=%0d", hit_cnt_o, miss_cnt_o, exp_hits, exp_misses);
        end
        n_checks++;
        if (dcache_valid_o !== 1'b0 || bmem_req_o !== 1'b0 || mem_read_data_o !== last_rd) begin
            n_fail++;
            $display("FAIL idle_after addr=%h got valid=%b req=%b data=%h expected valid=0 req=0 data=%h",
                     addr, dcache_valid_o, bmem_req_o, mem_read_data_o, last_rd);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        mem_read_en_i = 1'b0;
        mem_write_en_i = 1'b0;
        mem_addr_i = 16'h0;
        mem_write_data_i = 16'h0;
        bmem_ack_i = 1'b0;
        bmem_rdata_i = 16'h0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        n_checks++;
        if (bmem_req_o !== 1'b0 || bmem_we_o !== 1'b0 || bmem_addr_o !== 16'h0 || bmem_wdata_o !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_bmem got req=%b we=%b addr=%h wdata=%h expected all zero", bmem_req_o, bmem_we_o, bmem_addr_o, bmem_wdata_o);
        end
        n_checks++;
        if (dcache_valid_o !== 1'b0 || mem_read_data_o !== 16'h0 || hit_cnt_o !== 16'h0 || miss_cnt_o !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_lsu got valid=%b data=%h hit=%0d miss=%0d expected all zero", dcache_valid_o, mem_read_data_o, hit_cnt_o, miss_cnt_o);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_load_miss_hit();
        bm[16'h8000] = 16'hDEAD;
        access(1'b0, 1'b0, 16'h8000, 16'h0, 3);
        access(1'b0, 1'b0, 16'h8000, 16'h0, 3);
    endtask

    task automatic test_store_miss();
        access(1'b1, 1'b0, 16'h0040, 16'h4000, 2);
        access(1'b0, 1'b0, 16'h0040, 16'h0, 2);
    endtask

    task automatic test_store_hit();
        access(1'b1, 1'b0, 16'h8000, 16'h1221, 1);
        access(1'b0, 1'b0, 16'h8000, 16'h0, 1);
        access(1'b1, 1'b1, 16'h8000, 16'h5AA5, 2);
        access(1'b0, 1'b0, 16'h8000, 16'h0, 1);
    endtask

    task automatic test_index_wrap();
        access(1'b0, 1'b0, 16'h8010, 16'h0, 2);
        access(1'b0, 1'b0, 16'h8000, 16'h0, 2);
        access(1'b0, 1'b0, 16'h8000, 16'h0, 2);
    endtask

    task automatic test_reset_mid_fill();
        access(1'b0, 1'b0, 16'h8000, 16'h0, 1);
        mem_addr_i = 16'h8020;
        mem_read_en_i = 1'b1;
        @(posedge clk_i);
        #1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        mem_read_en_i = 1'b0;
        bmem_ack_i = 1'b1;
        bmem_rdata_i = 16'hBEEF;
        model_reset();
        @(negedge clk_i);
        n_checks++;
        if (bmem_req_o !== 1'b0 || dcache_valid_o !== 1'b0 || hit_cnt_o !== 16'h0 || miss_cnt_o !== 16'h0 || mem_read_data_o !== 16'h0) begin
            n_fail++;
            $display("FAIL mid_reset got req=%b valid=%b hit=%0d miss=%0d data=%h expected all zero",
                     bmem_req_o, dcache_valid_o, hit_cnt_o, miss_cnt_o, mem_read_data_o);
        end
        @(posedge clk_i);
        #1;
        bmem_ack_i = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if (bmem_req_o !== 1'b0 || dcache_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL late_ack got req=%b valid=%b expected req=0 valid=0", bmem_req_o, dcache_valid_o);
        end
        @(posedge clk_i);
        #1;
        access(1'b0, 1'b0, 16'h8000, 16'h0, 2);
        access(1'b0, 1'b0, 16'h8020, 16'h0, 2);
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic        wr;
        for (int n = 0; n < 60; n++) begin
            a = {2'($urandom_range(0, 3)), 10'd0, 4'($urandom_range(0, 3))};
            wr = ($urandom_range(0, 2) == 0);
            access(wr, wr && ($urandom_range(0, 1) == 1), a, 16'($urandom), $urandom_range(1, 4));
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) bm[i] = 16'($urandom);
        test_reset();
        test_load_miss_hit();
        test_store_miss();
        test_store_hit();
        test_index_wrap();
        test_reset_mid_fill();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
